// File: rtl/pitch_speed_pwm.sv
// rtl/pitch_speed_pwm.sv - pitch bin to debounced speed band and slew-limited PWM duty
// Optional feature: PITCH_WATCHDOG_EN (idle watchdog forcing duty to zero)
module pitch_speed_pwm #(
    parameter int BIN_W       = 10,
    parameter int LOW_TH      = 100,
    parameter int HIGH_TH     = 200,
    parameter int CONFIRM_N   = 3,
    parameter int PWM_PERIOD  = 1000,
    parameter int DUTY_SLOW   = 300,
    parameter int DUTY_MED    = 600,
    parameter int DUTY_FAST   = 900,
    parameter int RAMP_STEP   = 10,
    parameter int WDOG_CYCLES = 1843200
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 pitch_valid,
    input  logic [BIN_W-1:0]                     pitch_data,
    output logic [1:0]                           speed,
    output logic                                 speed_change,
    output logic [$clog2(PWM_PERIOD+1)-1:0]      duty,
    output logic                                 pwm_out,
    output logic                                 stale
);
    localparam int DW = $clog2(PWM_PERIOD + 1);
    localparam int AW = $clog2(CONFIRM_N + 1);
    localparam logic [BIN_W-1:0] LOW_B   = BIN_W'(LOW_TH);
    localparam logic [BIN_W-1:0] HIGH_B  = BIN_W'(HIGH_TH);
    localparam logic [DW-1:0]    D_SLOW  = DW'(DUTY_SLOW);
    localparam logic [DW-1:0]    D_MED   = DW'(DUTY_MED);
    localparam logic [DW-1:0]    D_FAST  = DW'(DUTY_FAST);
    localparam logic [DW-1:0]    STEP    = DW'(RAMP_STEP);
    localparam logic [DW-1:0]    LAST    = DW'(PWM_PERIOD - 1);
    localparam logic [AW-1:0]    CONF    = AW'(CONFIRM_N);

    typedef enum logic [1:0] {SLOW = 2'b00, MED = 2'b01, FAST = 2'b10} band_t;

    band_t          speed_q, candidate, band, cand_next;
    logic [AW-1:0]  agree_cnt, agree_next;
    logic [DW-1:0]  pwm_cnt, target, duty_next;
    logic           stale_q;

    always_comb begin
        band = (pitch_data < LOW_B) ? SLOW : (pitch_data >= HIGH_B) ? FAST : MED;
        cand_next  = band;
        agree_next = AW'(1);
        if (band == candidate) begin
            cand_next  = candidate;
            agree_next = (agree_cnt == CONF) ? CONF : agree_cnt + AW'(1);
        end
    end

    // Debounce FSM: the state is the speed register itself
`ifdef PITCH_WATCHDOG_EN
    localparam int IW = $clog2(WDOG_CYCLES + 1);
    localparam logic [IW-1:0] WDOG = IW'(WDOG_CYCLES);
    logic [IW-1:0] idle_cnt;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            speed_q      <= SLOW;
            speed_change <= 1'b0;
            candidate    <= SLOW;
            agree_cnt    <= '0;
            stale_q      <= 1'b0;
`ifdef PITCH_WATCHDOG_EN
            idle_cnt     <= '0;
`endif
        end else begin
            speed_change <= 1'b0;
            if (pitch_valid) begin
                candidate <= cand_next;
                agree_cnt <= agree_next;
                stale_q   <= 1'b0;
                if (agree_next == CONF && cand_next != speed_q) begin
                    speed_q      <= cand_next;
                    speed_change <= 1'b1;
                end
`ifdef PITCH_WATCHDOG_EN
                idle_cnt <= '0;
            end else if (idle_cnt != WDOG) begin
                idle_cnt <= idle_cnt + IW'(1);
                // Trip: restart debounce, hold speed, let the ramp take duty to zero
                if (idle_cnt == WDOG - IW'(1)) begin
                    stale_q   <= 1'b1;
                    candidate <= SLOW;
                    agree_cnt <= '0;
                end
`endif
            end
        end
    end

`ifdef PITCH_WATCHDOG_EN
    assign stale = stale_q;
`else
    // No idle counter in this build, so stale is constant 0
    assign stale = stale_q & (WDOG_CYCLES < 0);
`endif
    assign speed = speed_q;

    always_comb begin
        case (speed_q)
            SLOW:    target = D_SLOW;
            MED:     target = D_MED;
            default: target = D_FAST;
        endcase
        if (stale) target = '0;
        duty_next = duty;
        if (duty < target)
            duty_next = (target - duty > STEP) ? duty + STEP : target;
        else if (duty > target)
            duty_next = (duty - target > STEP) ? duty - STEP : target;
    end

    // Duty is only updated on the wrap edge so a period never changes mid-way
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_cnt <= '0;
            duty    <= '0;
            pwm_out <= 1'b0;
        end else begin
            pwm_out <= (pwm_cnt < duty);
            if (pwm_cnt == LAST) begin
                pwm_cnt <= '0;
                duty    <= duty_next;
            end else begin
                pwm_cnt <= pwm_cnt + DW'(1);
            end
        end
    end
endmodule
